apb_rr_master_arbiter: RTL and testbench



---
 rtl/apb_rr_master_arbiter.sv | 174 +++++++++++++++++
 tb/tb_apb_rr_master_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_master_arbiter.sv
// rtl/apb_rr_master_arbiter.sv - round-robin arbiter sharing one APB master port among NUM_REQ requesters
// Wait-state timeout aborts the transfer with rsp_err; all outputs come straight from flops.
module apb_rr_master_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic                        PSEL,
  output logic                        PENABLE,
  output logic                        PWRITE,
  output logic [ADDR_W-1:0]           PADDR,
  output logic [DATA_W-1:0]           PWDATA,
  input  logic [DATA_W-1:0]           PRDATA,
  input  logic                        PREADY,
  input  logic                        PSLVERR
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;

  logic                grant_found;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W-1:0]    cand_idx;
  logic                timeout_hit;

  // Search starts one past the last grantee so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    req_ready_d  = '0;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          req_ready_d[grant_idx] = 1'b1;
          paddr_d      = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
          pwdata_d     = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
          pwrite_d     = req_write[grant_idx];
          psel_d       = 1'b1;
          penable_d    = 1'b0;
          last_grant_d = grant_idx;
          wait_cnt_d   = '0;
          state_d      = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (PREADY) begin
          psel_d                    = 1'b0;
          penable_d                 = 1'b0;
          rsp_valid_d[last_grant_q] = 1'b1;
          rsp_rdata_d               = pwrite_q ? '0 : PRDATA;
          rsp_err_d                 = PSLVERR;
          state_d                   = ST_IDLE;
        end else if (timeout_hit) begin
          psel_d                    = 1'b0;
          penable_d                 = 1'b0;
          rsp_valid_d[last_grant_q] = 1'b1;
          rsp_rdata_d               = '0;
          rsp_err_d                 = 1'b1;
          state_d                   = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q      <= ST_IDLE;
      last_grant_q <= LAST_RST;
      wait_cnt_q   <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// tb/tb_apb_rr_master_arbiter.sv - self-checking bench for apb_rr_master_arbiter
// Vector table, hand sequences for round-robin/reset, then randomized traffic against a transfer-level model.
module tb_apb_rr_master_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic [N-1:0]    req_valid, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            PSEL, PENABLE, PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA;
  logic [DW-1:0]   PRDATA;
  logic            PREADY, PSLVERR;

  logic [N-1:0]    r_valid;
  logic            r_write [N];
  logic [31:0]     r_addr  [N];
  logic [31:0]     r_wdata [N];

  int checks = 0;
  int errors = 0;
  int model_last = N - 1;

  always #5 PCLK = ~PCLK;

  always_comb begin
    req_valid = r_valid;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_write[i]          = r_write[i];
      req_addr[i*AW +: AW]  = r_addr[i];
      req_wdata[i*DW +: DW] = r_wdata[i];
    end
  end

  apb_rr_master_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct {
    int          g;
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    logic        slverr;
    int          n_acc;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  // Requesters examined in rotation order after the previous winner.
  function automatic int rr_pick(input logic [N-1:0] m, input int last);
    int order [$];
    for (int k = 1; k <= N; k++) order.push_back((last + k) % N);
    foreach (order[j]) if (m[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, {req_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE}, '0);
    chk({name, "_paddr"}, PADDR, '0);
    chk({name, "_pwdata"}, PWDATA, '0);
    chk({name, "_rdata"}, rsp_rdata, '0);
  endtask

  task automatic do_reset();
    PRESET  = 1'b1;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    @(negedge PCLK);
    @(negedge PCLK);
    PRESET     = 1'b0;
    model_last = N - 1;
  endtask

  // Called at a negedge just before an IDLE edge; grant must appear at that very edge.
  task automatic xfer(input int g, input int waits, input logic slverr, input logic [31:0] prdata,
                      input int n_acc, input logic exp_err, input logic [31:0] exp_rd, input logic keep);
    logic [31:0] a, wd;
    logic        w;
    a  = r_addr[g];
    wd = r_wdata[g];
    w  = r_write[g];
    @(negedge PCLK);
    chk("grant", req_ready, onehot(g));
    chk("setup_ctl", {PSEL, PENABLE, |rsp_valid}, 3'b100);
    chk("setup_paddr", PADDR, a);
    chk("setup_pwrite", PWRITE, w);
    chk("setup_pwdata", PWDATA, wd);
    if (!keep) r_valid[g] = 1'b0;
    PREADY  = 1'b1;
    PSLVERR = 1'b1;
    PRDATA  = $urandom;
    @(negedge PCLK);
    chk("access_ctl", {PSEL, PENABLE, |req_ready, |rsp_valid}, 4'b1100);
    chk("access_paddr", PADDR, a);
    chk("access_pwdata", PWDATA, wd);
    for (int c = 0; c < n_acc; c++) begin
      PREADY  = (c == waits);
      PSLVERR = (c == waits) ? slverr : 1'($urandom);
      PRDATA  = (c == waits) ? prdata : $urandom;
      @(negedge PCLK);
      if (c < n_acc - 1) chk("wait_ctl", {PSEL, PENABLE, |rsp_valid}, 3'b110);
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    chk("rsp_valid", rsp_valid, onehot(g));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", rsp_err, exp_err);
    chk("done_ctl", {PSEL, PENABLE, |req_ready}, 3'b000);
    model_last = g;
  endtask

  task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    r_valid[i] = 1'b1;
    r_write[i] = w;
    r_addr[i]  = a;
    r_wdata[i] = d;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    r_valid = '0;
    for (int i = 0; i < N; i++) begin
      r_write[i] = 1'b0;
      r_addr[i]  = '0;
      r_wdata[i] = '0;
    end
    do_reset();
    chk_all_zero("reset");

    //           g  w     addr     wdata     prdata    waits slverr n_acc err  rd
    vecs[0] = '{0, 1'b1, 32'h10, 32'h1234, 32'hDEAD, 0,    1'b0,  1,    1'b0, 32'h0};
    vecs[1] = '{1, 1'b0, 32'h20, 32'h0,    32'hCAFE, 2,    1'b0,  3,    1'b0, 32'hCAFE};
    vecs[2] = '{0, 1'b0, 32'h30, 32'h0,    32'hBEEF, 9,    1'b0,  4,    1'b1, 32'h0};
    vecs[3] = '{1, 1'b1, 32'h40, 32'h5555, 32'h7777, 1,    1'b0,  2,    1'b0, 32'h0};
    vecs[4] = '{0, 1'b1, 32'h50, 32'hAAAA, 32'h9999, 0,    1'b1,  1,    1'b1, 32'h0};
    vecs[5] = '{0, 1'b0, 32'h60, 32'h0,    32'h1357, 0,    1'b0,  1,    1'b0, 32'h1357};
    vecs[6] = '{2, 1'b0, 32'h70, 32'h0,    32'h2468, 3,    1'b0,  4,    1'b0, 32'h2468};

    for (int v = 0; v < 7; v++) begin
      r_valid = '0;
      set_req(vecs[v].g, vecs[v].w, vecs[v].addr, vecs[v].wdata);
      xfer(vecs[v].g, vecs[v].waits, vecs[v].slverr, vecs[v].prdata,
           vecs[v].n_acc, vecs[v].err, vecs[v].rd, 1'b0);
    end

    // Response fields hold once the pulse is gone.
    @(negedge PCLK);
    chk("hold_valid", rsp_valid, '0);
    chk("hold_rdata", rsp_rdata, 32'h2468);
    chk("hold_err", rsp_err, 1'b0);

    // Two requesters asserting continuously alternate from requester 0.
    do_reset();
    set_req(0, 1'b1, 32'h100, 32'h11);
    set_req(1, 1'b0, 32'h200, 32'h22);
    xfer(0, 0, 1'b0, 32'h0,  1, 1'b0, 32'h0,  1'b1);
    xfer(1, 0, 1'b0, 32'h5A, 1, 1'b0, 32'h5A, 1'b1);
    xfer(0, 1, 1'b0, 32'h0,  2, 1'b0, 32'h0,  1'b1);
    xfer(1, 0, 1'b0, 32'hA5, 1, 1'b0, 32'hA5, 1'b1);
    r_valid = '0;

    // Reset during ACCESS: no response, and the pointer returns to requester 0.
    set_req(0, 1'b0, 32'h300, 32'h0);
    @(negedge PCLK);
    chk("t6_grant", req_ready, onehot(0));
    r_valid[0] = 1'b0;
    PREADY     = 1'b0;
    @(negedge PCLK);
    chk("t6_access", {PSEL, PENABLE}, 2'b11);
    set_req(0, 1'b0, 32'h310, 32'h0);
    set_req(1, 1'b1, 32'h400, 32'h44);
    PRESET = 1'b1;
    PREADY = 1'b1;
    @(negedge PCLK);
    chk_all_zero("t6_reset");
    PRESET     = 1'b0;
    PREADY     = 1'b0;
    model_last = N - 1;
    xfer(0, 0, 1'b0, 32'h600D, 1, 1'b0, 32'h600D, 1'b0);
    xfer(1, 0, 1'b0, 32'h0,    1, 1'b0, 32'h0,    1'b0);

    // Randomized traffic against the transfer-level model.
    r_valid = '0;
    for (int t = 0; t < 80; t++) begin
      int          g, waits, n_acc;
      logic        slverr, e_err;
      logic [31:0] prd, e_rd;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) == 0) r_valid[i] = 1'b0;
        else if (!r_valid[i]) set_req(i, 1'($urandom), $urandom, $urandom);
      end
      if (r_valid == '0) begin
        int i;
        i = $urandom_range(0, N - 1);
        set_req(i, 1'($urandom), $urandom, $urandom);
      end
      g      = rr_pick(r_valid, model_last);
      waits  = $urandom_range(0, 5);
      slverr = 1'($urandom);
      prd    = $urandom;
      if (waits >= TO) begin
        n_acc = TO;
        e_err = 1'b1;
        e_rd  = '0;
      end else begin
        n_acc = waits + 1;
        e_err = slverr;
        e_rd  = r_write[g] ? 32'h0 : prd;
      end
      xfer(g, waits, slverr, prd, n_acc, e_err, e_rd, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
